// File: rtl/spi_cmd_seq.sv
// Turns one host register write/read into a contiguous multi-byte frame on the
// 8-bit SPI master, with a per-byte timeout and a CS-high gap between frames.
module spi_cmd_seq #(
    parameter logic [7:0]  CMD_WR     = 8'h02,
    parameter logic [7:0]  CMD_RD     = 8'h03,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_req_valid,
    output logic       O_req_ready,
    input  logic       I_req_rw,
    input  logic [7:0] I_req_addr,
    input  logic [7:0] I_req_wdata,
    output logic       O_rsp_valid,
    output logic [7:0] O_rsp_rdata,
    output logic       O_rsp_err,
    output logic       O_tx_en,
    output logic       O_rx_en,
    output logic [7:0] O_data_in,
    input  logic       I_tx_done,
    input  logic       I_rx_done,
    input  logic [7:0] I_data_out
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, TX_CMD, TX_ADDR, TX_DATA, RX_DATA, GAP
    } state_t;

    state_t        state_q, state_d;
    logic          rw_q, rw_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          tx_en_q, tx_en_d;
    logic          rx_en_q, rx_en_d;
    logic [7:0]    data_q, data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          abort;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tcnt_q      <= '0;
            gcnt_q      <= '0;
            tx_en_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tcnt_q      <= tcnt_d;
            gcnt_q      <= gcnt_d;
            tx_en_q     <= tx_en_d;
            rx_en_q     <= rx_en_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tcnt_d      = tcnt_q;
        gcnt_d      = gcnt_q;
        tx_en_d     = tx_en_q;
        rx_en_d     = rx_en_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        abort       = 1'b0;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                gcnt_d = '0;
                if (I_req_valid) begin
                    rw_d    = I_req_rw;
                    addr_d  = I_req_addr;
                    wdata_d = I_req_wdata;
                    data_d  = I_req_rw ? CMD_WR : CMD_RD;
                    tx_en_d = 1'b1;
                    state_d = TX_CMD;
                end
            end
            TX_CMD: begin
                if (I_tx_done) begin
                    tcnt_d  = '0;
                    data_d  = addr_q;
                    state_d = TX_ADDR;
                end else if (tcnt_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            TX_ADDR: begin
                if (I_tx_done) begin
                    tcnt_d = '0;
                    if (rw_q) begin
                        data_d  = wdata_q;
                        state_d = TX_DATA;
                    end else begin
                        // Enable handover on one edge keeps CS low into the read byte
                        tx_en_d = 1'b0;
                        rx_en_d = 1'b1;
                        data_d  = '0;
                        state_d = RX_DATA;
                    end
                end else if (tcnt_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            TX_DATA: begin
                if (I_tx_done) begin
                    tcnt_d      = '0;
                    gcnt_d      = '0;
                    tx_en_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    state_d     = GAP;
                end else if (tcnt_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            RX_DATA: begin
                if (I_rx_done) begin
                    tcnt_d      = '0;
                    gcnt_d      = '0;
                    rx_en_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = I_data_out;
                    err_d       = 1'b0;
                    state_d     = GAP;
                end else if (tcnt_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            tcnt_d      = '0;
            gcnt_d      = '0;
            tx_en_d     = 1'b0;
            rx_en_d     = 1'b0;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
            err_d       = 1'b1;
            state_d     = GAP;
        end
    end

    assign O_req_ready = (state_q == IDLE);
    assign O_rsp_valid = rsp_valid_q;
    assign O_rsp_rdata = rdata_q;
    assign O_rsp_err   = err_q;
    assign O_tx_en     = tx_en_q;
    assign O_rx_en     = rx_en_q;
    assign O_data_in   = data_q;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq with a cycle-level model of the SPI master
// (16-cycle tx bytes, 17-cycle rx byte after handover) recording MOSI bytes.
module tb_spi_cmd_seq;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       tx_en;
    logic       rx_en;
    logic [7:0] data_in;
    logic       tx_done;
    logic       rx_done;
    logic [7:0] data_out;

    logic        m_tx, m_rx, tx_stub, f_tx, f_rx;
    logic [7:0]  m_dout, slave_byte;
    int unsigned tcnt, rcnt;
    logic [7:0]  mosi[$];

    int checks;
    int failures;
    logic ok;

    spi_cmd_seq #(
        .CMD_WR(8'h02),
        .CMD_RD(8'h03),
        .GAP_CYCLES(4),
        .TIMEOUT(64)
    ) dut (
        .I_clk(clk),
        .I_rst_n(rst_n),
        .I_req_valid(req_valid),
        .O_req_ready(req_ready),
        .I_req_rw(req_rw),
        .I_req_addr(req_addr),
        .I_req_wdata(req_wdata),
        .O_rsp_valid(rsp_valid),
        .O_rsp_rdata(rsp_rdata),
        .O_rsp_err(rsp_err),
        .O_tx_en(tx_en),
        .O_rx_en(rx_en),
        .O_data_in(data_in),
        .I_tx_done(tx_done),
        .I_rx_done(rx_done),
        .I_data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_done  = (m_tx & ~tx_stub) | f_tx;
    assign rx_done  = m_rx | f_rx;
    assign data_out = m_dout;

    // Master model: tx done pulse every 16 enabled cycles, rx done 17 cycles after handover
    always @(posedge clk) begin
        if (tx_done && tx_en) mosi.push_back(data_in);
        if (tx_en) begin
            tcnt <= (tcnt == 15) ? 0 : tcnt + 1;
            m_tx <= (tcnt == 14);
        end else begin
            tcnt <= 0;
            m_tx <= 1'b0;
        end
        if (rx_en) begin
            rcnt   <= rcnt + 1;
            m_rx   <= (rcnt == 15);
            m_dout <= (rcnt == 15) ? slave_byte : 8'hEE;
        end else begin
            rcnt   <= 0;
            m_rx   <= 1'b0;
            m_dout <= 8'hEE;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int unsigned n;
        n = 0;
        while (!req_ready && n < 200) begin
            tick(1);
            n++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic rw, input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        tx_stub = 1'b0; f_tx = 1'b0; f_rx = 1'b0; slave_byte = 8'h00;
        m_tx = 1'b0; m_rx = 1'b0; m_dout = 8'hEE; tcnt = 0; rcnt = 0;

        // Reset state
        tick(1);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outs", {20'd0, rsp_valid, rsp_err, tx_en, rx_en, data_in}, 32'd0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // Write 5A <- C3
        wait_ready();
        mosi.delete();
        issue(1'b1, 8'h5A, 8'hC3);
        tick(1);
        chk("wr_e0", {22'd0, tx_en, req_ready, data_in}, {22'd0, 1'b1, 1'b0, 8'h02});
        req_valid = 1'b0; req_addr = 8'hFF; req_wdata = 8'h00; req_rw = 1'b0;
        ok = 1'b1;
        for (int i = 1; i < 48; i++) begin
            tick(1);
            ok &= tx_en & ~rx_en & ~rsp_valid & ~req_ready;
        end
        chk("wr_txen_contig", {31'd0, ok}, 32'd1);
        tick(1);
        chk("wr_rsp48", {29'd0, rsp_valid, rsp_err, tx_en}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("wr_rdata", {24'd0, rsp_rdata}, 32'd0);
        tick(1);
        chk("wr_rsp_1cyc", {31'd0, rsp_valid}, 32'd0);
        chk("wr_mosi_n", mosi.size(), 32'd3);
        chk("wr_mosi", {8'd0, mosi[0], mosi[1], mosi[2]}, 32'h00025AC3);

        // Read 10, slave returns A5
        wait_ready();
        mosi.delete();
        slave_byte = 8'hA5;
        issue(1'b0, 8'h10, 8'h99);
        tick(1);
        chk("rd_e0", {24'd0, data_in}, 32'h03);
        req_valid = 1'b0;
        ok = 1'b1;
        for (int i = 1; i < 32; i++) begin
            tick(1);
            ok &= tx_en & ~rx_en;
        end
        chk("rd_tx_phase", {31'd0, ok}, 32'd1);
        tick(1);
        chk("rd_handover", {22'd0, tx_en, rx_en, data_in}, {22'd0, 1'b0, 1'b1, 8'h00});
        ok = 1'b1;
        for (int i = 33; i < 49; i++) begin
            tick(1);
            ok &= rx_en & ~tx_en & ~rsp_valid;
        end
        chk("rd_rx_phase", {31'd0, ok}, 32'd1);
        tick(1);
        chk("rd_rsp49", {30'd0, rsp_valid, rsp_err}, {30'd0, 1'b1, 1'b0});
        chk("rd_rdata", {24'd0, rsp_rdata}, 32'hA5);
        chk("rd_mosi", {mosi.size() == 2, 15'd0, mosi[0], mosi[1]}, {1'b1, 15'd0, 16'h0310});
        tick(1);
        chk("rd_rdata_hold", {23'd0, rsp_valid, rsp_rdata}, {23'd0, 1'b0, 8'hA5});

        // Timeout: tx_done suppressed after the command byte
        wait_ready();
        issue(1'b1, 8'h77, 8'h88);
        tick(1);
        req_valid = 1'b0;
        tick(16);
        chk("to_in_addr", {23'd0, tx_en, data_in}, {23'd0, 1'b1, 8'h77});
        tx_stub = 1'b1;
        ok = 1'b1;
        for (int i = 17; i < 80; i++) begin
            tick(1);
            ok &= tx_en & ~rsp_valid;
        end
        chk("to_waiting", {31'd0, ok}, 32'd1);
        tick(1);
        chk("to_abort", {28'd0, tx_en, rx_en, rsp_valid, rsp_err}, {28'd0, 4'b0011});
        chk("to_rdata", {24'd0, rsp_rdata}, 32'd0);
        tx_stub = 1'b0;

        // Back-to-back writes with req_valid held
        wait_ready();
        issue(1'b1, 8'h21, 8'h31);
        tick(1);
        req_addr = 8'h22; req_wdata = 8'h42;
        ok = 1'b1;
        for (int i = 1; i < 48; i++) begin
            tick(1);
            ok &= ~req_ready;
        end
        chk("b2b_ready_low", {31'd0, ok}, 32'd1);
        tick(1);
        chk("b2b_rsp1", {30'd0, rsp_valid, rsp_err}, {30'd0, 1'b1, 1'b0});
        ok = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick(1);
            ok &= ~req_ready & ~tx_en;
        end
        chk("b2b_gap", {31'd0, ok}, 32'd1);
        tick(1);
        chk("b2b_idle", {30'd0, req_ready, tx_en}, {30'd0, 1'b1, 1'b0});
        tick(1);
        mosi.delete();
        chk("b2b_accept2", {22'd0, tx_en, req_ready, data_in}, {22'd0, 1'b1, 1'b0, 8'h02});
        req_valid = 1'b0;
        tick(48);
        chk("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_mosi2", {mosi.size() == 3, 7'd0, mosi[0], mosi[1], mosi[2]}, {1'b1, 7'd0, 24'h022242});

        // Spurious dones and simultaneous dones
        wait_ready();
        f_tx = 1'b1;
        tick(1);
        f_tx = 1'b0;
        chk("sp_idle_txdone", {30'd0, req_ready, tx_en}, {30'd0, 1'b1, 1'b0});
        mosi.delete();
        slave_byte = 8'h3C;
        issue(1'b0, 8'h44, 8'h00);
        tick(1);
        req_valid = 1'b0;
        tick(4);
        f_rx = 1'b1;
        tick(1);
        f_rx = 1'b0;
        chk("sp_cmd_rxdone", {22'd0, tx_en, rx_en, data_in}, {22'd0, 1'b1, 1'b0, 8'h03});
        tick(11);
        chk("sp_addr_on_time", {24'd0, data_in}, 32'h44);
        tick(32);
        chk("sp_rx_pending", {30'd0, rx_en, rsp_valid}, {30'd0, 1'b1, 1'b0});
        f_tx = 1'b1;
        tick(1);
        f_tx = 1'b0;
        chk("sp_both_done", {23'd0, rsp_valid, rsp_rdata}, {23'd0, 1'b1, 8'h3C});

        // Async reset in the middle of RX_DATA, then a clean read
        wait_ready();
        slave_byte = 8'h5E;
        issue(1'b0, 8'h55, 8'h00);
        tick(1);
        req_valid = 1'b0;
        tick(40);
        chk("mr_in_rx", {31'd0, rx_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_ready", {31'd0, req_ready}, 32'd1);
        chk("mr_async_outs", {20'd0, rsp_valid, rsp_err, tx_en, rx_en, data_in}, 32'd0);
        chk("mr_async_rdata", {24'd0, rsp_rdata}, 32'd0);
        tick(1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        chk("mr_post_ready", {31'd0, req_ready}, 32'd1);
        mosi.delete();
        issue(1'b0, 8'h66, 8'h00);
        tick(1);
        req_valid = 1'b0;
        tick(48);
        chk("mr_rd_not_yet", {31'd0, rsp_valid}, 32'd0);
        tick(1);
        chk("mr_rd_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, {22'd0, 1'b1, 1'b0, 8'h5E});
        chk("mr_rd_mosi", {mosi.size() == 2, 15'd0, mosi[0], mosi[1]}, {1'b1, 15'd0, 16'h0366});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
